// File: rtl/mips_shift_pkg.sv
// mips_shift_pkg: shared op and state encodings for the iterative shifter.
package mips_shift_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: shifts a value by k (1..4) bits with the fill selected by op.
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [1:0]       i_op,
  input  logic [2:0]       i_k,
  output logic [WIDTH-1:0] o_value
);
  import mips_shift_pkg::*;
  logic signed [WIDTH-1:0] w_sra;
  assign w_sra = $signed(i_value) >>> i_k;
  // reserved op 2'b10 falls through to the logical right shift
  assign o_value = i_op == OP_SLL ? i_value << i_k : i_op == OP_SRA ? w_sra : i_value >> i_k;
endmodule

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA with start/busy/done handshake.
// Define SHIFT_UNIT_FAST4_EN to shift up to four bits per cycle instead of one.
module shift_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);
  import mips_shift_pkg::*;
  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_count;
  logic [1:0]         r_op;
  logic [2:0]         w_k;
  logic [SHAMT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_accept;
`ifdef SHIFT_UNIT_FAST4_EN
  assign w_k = r_count > SHAMT_W'(4) ? 3'd4 : r_count[2:0];
`else
  assign w_k = 3'd1;
`endif
  assign w_count_nxt = r_count - SHAMT_W'(w_k);
  assign w_accept    = start && r_state != ST_SHIFT;
  assign busy        = r_state == ST_SHIFT;
  assign done        = r_state == ST_DONE;
  assign result      = r_result;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_value(r_work),
    .i_op   (r_op),
    .i_k    (w_k),
    .o_value(w_shifted)
  );
  always_comb begin
    w_next = ST_IDLE;
    if (w_accept) w_next = shamt == '0 ? ST_DONE : ST_SHIFT;
    else if (r_state == ST_SHIFT) w_next = w_count_nxt == '0 ? ST_DONE : ST_SHIFT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_count  <= '0;
      r_op     <= OP_SLL;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work  <= a;
        r_count <= shamt;
        r_op    <= op;
        if (shamt == '0) r_result <= a;
      end else if (r_state == ST_SHIFT) begin
        r_work  <= w_shifted;
        r_count <= w_count_nxt;
        if (w_count_nxt == '0) r_result <= w_shifted;
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed vector table plus multi-cycle corner sequences.
module tb_shift_unit_iter;
  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] a, result;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  shift_unit_iter dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt),
    .a(a), .busy(busy), .done(done), .result(result)
  );
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];
  function automatic int lat(input logic [4:0] s);
`ifdef SHIFT_UNIT_FAST4_EN
    return (int'(s) + 3) / 4 + 1;
`else
    return int'(s) + 1;
`endif
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v);
    op = o; shamt = s; a = v; start = 1'b1;
    tick();
    start = 1'b0; a = 32'h5A5A_5A5A; shamt = 5'd17; op = 2'b00;
  endtask
  task automatic wait_done(input string name, input int c0, input int exp_lat, input logic [31:0] exp);
    int c = c0;
    while (done !== 1'b1 && c < 64) begin
      tick();
      c++;
    end
    check({name, " done"}, {31'b0, done}, 32'd1);
    check({name, " latency"}, c, exp_lat);
    check({name, " result"}, result, exp);
    check({name, " busy@done"}, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; a = 32'd0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle done", {31'b0, done}, 32'd0);
      check("idle result", result, 32'd0);
    end
    vecs[0]  = '{2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010};
    vecs[1]  = '{2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[3]  = '{2'b11, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[4]  = '{2'b11, 5'd1,  32'h8000_0000, 32'hC000_0000};
    vecs[5]  = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6]  = '{2'b10, 5'd8,  32'hF000_0000, 32'h00F0_0000};
    vecs[7]  = '{2'b11, 5'd5,  32'h7FFF_FFFF, 32'h03FF_FFFF};
    vecs[8]  = '{2'b01, 5'd16, 32'hDEAD_BEEF, 32'h0000_DEAD};
    vecs[9]  = '{2'b00, 5'd7,  32'h1234_5678, 32'h1A2B_3C00};
    vecs[10] = '{2'b11, 5'd6,  32'h8000_0000, 32'hFE00_0000};
    vecs[11] = '{2'b11, 5'd3,  32'hF000_0000, 32'hFE00_0000};
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].shamt, vecs[i].a);
      wait_done($sformatf("vec%0d", i), 1, lat(vecs[i].shamt), vecs[i].exp);
      tick();
      check($sformatf("vec%0d done pulse", i), {31'b0, done}, 32'd0);
      check($sformatf("vec%0d hold", i), result, vecs[i].exp);
    end
    // start while busy is ignored; then a start on the DONE cycle chains directly
    issue(2'b01, 5'd8, 32'h8000_0000);
    tick();
    op = 2'b00; shamt = 5'd0; a = 32'hFFFF_FFFF; start = 1'b1;
    check("ign busy", {31'b0, busy}, 32'd1);
    tick();
    start = 1'b0;
    wait_done("ign", 3, lat(5'd8), 32'h0080_0000);
    issue(2'b01, 5'd4, 32'h0000_00F0);
    check("b2b busy", {31'b0, busy}, 32'd1);
    check("b2b old result", result, 32'h0080_0000);
    wait_done("b2b", 1, lat(5'd4), 32'h0000_000F);
    // reset in the middle of a shift aborts it without a done pulse
    tick();
    issue(2'b01, 5'd10, 32'h8000_0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        seen |= done;
      end
      check("abort no done", {31'b0, seen}, 32'd0);
    end
    issue(2'b00, 5'd2, 32'h0000_0003);
    wait_done("post abort", 1, lat(5'd2), 32'h0000_000C);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
